// File: rtl/imu_sched.sv
// IMU read scheduler: runs the IMU init writes after power-on, then on each
// data-ready interrupt reads pitch and pitch-rate bytes over SPI and presents them.
module imu_sched #(
  parameter bit fast_sim = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [15:0] ptch,
  output logic [15:0] ptch_rt,
  output logic        vld
);

  localparam int unsigned TMR_W  = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned BYTE_W = 8;

  localparam logic [DATA_W-1:0] CMD_INIT1 = 16'h0D02;
  localparam logic [DATA_W-1:0] CMD_INIT2 = 16'h1053;
  localparam logic [DATA_W-1:0] CMD_INIT3 = 16'h1150;
  localparam logic [DATA_W-1:0] CMD_INIT4 = 16'h1460;
  localparam logic [DATA_W-1:0] CMD_RD_PL = 16'hA200;
  localparam logic [DATA_W-1:0] CMD_RD_PH = 16'hA300;
  localparam logic [DATA_W-1:0] CMD_RD_RL = 16'hA400;
  localparam logic [DATA_W-1:0] CMD_RD_RH = 16'hA500;

  typedef enum logic [3:0] {
    INIT_WAIT,
    INIT1,
    INIT2,
    INIT3,
    INIT4,
    IDLE,
    RD_PL,
    RD_PH,
    RD_RL,
    RD_RH,
    VLD_OUT
  } state_t;

  state_t              r_state;
  logic [TMR_W-1:0]    r_timer;
  logic                r_int_ff1;
  logic                r_int_ff2;
  logic                r_wrt;
  logic                r_vld;
  logic [DATA_W-1:0]   r_cmd;
  logic [DATA_W-1:0]   r_ptch;
  logic [DATA_W-1:0]   r_ptch_rt;
  logic [BYTE_W-1:0]   r_pl;
  logic [BYTE_W-1:0]   r_ph;
  logic [BYTE_W-1:0]   r_rl;
  logic [BYTE_W-1:0]   r_rh;

  logic                w_timer_done;
  logic [BYTE_W-1:0]   w_rd_byte;
  logic                w_unused_rd;

  // Power-on wait is shortened for simulation.
  assign w_timer_done = fast_sim ? (&r_timer[9:0]) : (&r_timer);
  assign w_rd_byte    = rd_data[BYTE_W-1:0];
  assign w_unused_rd  = |rd_data[DATA_W-1:BYTE_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= INIT_WAIT;
      r_timer   <= '0;
      r_int_ff1 <= 1'b0;
      r_int_ff2 <= 1'b0;
      r_wrt     <= 1'b0;
      r_vld     <= 1'b0;
      r_cmd     <= '0;
      r_ptch    <= '0;
      r_ptch_rt <= '0;
      r_pl      <= '0;
      r_ph      <= '0;
      r_rl      <= '0;
      r_rh      <= '0;
    end else begin
      r_int_ff1 <= INT;
      r_int_ff2 <= r_int_ff1;
      r_wrt     <= 1'b0;
      r_vld     <= 1'b0;
      case (r_state)
        INIT_WAIT: begin
          r_timer <= r_timer + TMR_W'(1);
          if (w_timer_done) begin
            r_state <= INIT1;
            r_wrt   <= 1'b1;
            r_cmd   <= CMD_INIT1;
          end
        end
        INIT1: if (done) begin
          r_state <= INIT2;
          r_wrt   <= 1'b1;
          r_cmd   <= CMD_INIT2;
        end
        INIT2: if (done) begin
          r_state <= INIT3;
          r_wrt   <= 1'b1;
          r_cmd   <= CMD_INIT3;
        end
        INIT3: if (done) begin
          r_state <= INIT4;
          r_wrt   <= 1'b1;
          r_cmd   <= CMD_INIT4;
        end
        INIT4: if (done) begin
          r_state <= IDLE;
        end
        IDLE: if (r_int_ff2) begin
          r_state <= RD_PL;
          r_wrt   <= 1'b1;
          r_cmd   <= CMD_RD_PL;
        end
        // Byte captures stay private until the whole pair has been read.
        RD_PL: if (done) begin
          r_pl    <= w_rd_byte;
          r_state <= RD_PH;
          r_wrt   <= 1'b1;
          r_cmd   <= CMD_RD_PH;
        end
        RD_PH: if (done) begin
          r_ph    <= w_rd_byte;
          r_state <= RD_RL;
          r_wrt   <= 1'b1;
          r_cmd   <= CMD_RD_RL;
        end
        RD_RL: if (done) begin
          r_rl    <= w_rd_byte;
          r_state <= RD_RH;
          r_wrt   <= 1'b1;
          r_cmd   <= CMD_RD_RH;
        end
        RD_RH: if (done) begin
          r_rh    <= w_rd_byte;
          r_state <= VLD_OUT;
        end
        VLD_OUT: begin
          r_ptch    <= {r_ph, r_pl};
          r_ptch_rt <= {r_rh, r_rl};
          r_vld     <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= INIT_WAIT;
      endcase
    end
  end

  assign wrt     = r_wrt;
  assign cmd     = r_cmd;
  assign ptch    = r_ptch;
  assign ptch_rt = r_ptch_rt;
  assign vld     = r_vld;

endmodule

// File: doc/imu_sched.md
IMU_SCHED -- requirements
Module: imu_sched

Interface
REQ-001 Parameter: fast_sim, default 1, selects a shortened power-on wait (1 = 1024 clocks, 0 = 65536 clocks).
REQ-002 Port: clk  input  1  system clock; all state on the rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: INT  input  1  IMU data-ready, asynchronous to clk.
REQ-005 Port: done  input  1  SPI master transaction complete, single-cycle pulse.
REQ-006 Port: rd_data  input  16  SPI master read data; valid in the done cycle; only bits [7:0] used.
REQ-007 Port: wrt  output  1  SPI master start, single-cycle pulse.
REQ-008 Port: cmd  output  16  SPI command word; held stable from the wrt cycle through done.
REQ-009 Port: ptch  output  16  signed pitch sample for balance control.
REQ-010 Port: ptch_rt  output  16  signed pitch-rate sample for balance control.
REQ-011 Port: vld  output  1  new ptch/ptch_rt pair, single-cycle pulse.

Function
REQ-012 INT SHALL pass through two flops before use; any logic reading INT SHALL see only the second flop output.
REQ-013 State machine states: INIT_WAIT, INIT1, INIT2, INIT3, INIT4, IDLE, RD_PL, RD_PH, RD_RL, RD_RH, VLD_OUT.
REQ-014 INIT_WAIT behaviour:
- a 16-bit timer counts up every clock.
- exit to INIT1 when timer[9:0] is all ones (fast_sim=1) or timer[15:0] is all ones (fast_sim=0).
- on exit, assert wrt with cmd 0x0D02.
REQ-015 Init writes, each sent on the done of the previous command:
- INIT1 done -> INIT2, wrt with cmd 0x1053.
- INIT2 done -> INIT3, wrt with cmd 0x1150.
- INIT3 done -> INIT4, wrt with cmd 0x1460.
- INIT4 done -> IDLE.
REQ-016 IDLE: when synchronized INT is 1, go to RD_PL and assert wrt with cmd 0xA200 in the same transition.
REQ-017 Read sequence, each step taken on done:
- RD_PL done: capture rd_data[7:0] as pitch low; go to RD_PH with wrt, cmd 0xA300.
- RD_PH done: capture pitch high; go to RD_RL with wrt, cmd 0xA400.
- RD_RL done: capture rate low; go to RD_RH with wrt, cmd 0xA500.
- RD_RH done: capture rate high; go to VLD_OUT.
REQ-018 VLD_OUT, one cycle only:
- ptch <= {pitch high, pitch low}; ptch_rt <= {rate high, rate low}.
- vld = 1; go to IDLE.
REQ-019 ptch and ptch_rt SHALL change only in the VLD_OUT cycle; a partial read never alters them.
REQ-020 wrt SHALL pulse exactly once per command; no new wrt while a transaction is outstanding (between wrt and its done).
REQ-021 done arriving in IDLE, INIT_WAIT or VLD_OUT SHALL be ignored.
REQ-022 INT high during a read sequence SHALL be ignored.
REQ-023 INT still high on return to IDLE SHALL start a new sequence the next cycle, so minimum spacing between vld pulses is 4 transactions plus 2 cycles.
REQ-024 Without done, each state SHALL wait indefinitely; no timeout.
REQ-025 cmd SHALL hold its last value while in IDLE.

Reset
REQ-026 On rst_n=0, immediately and regardless of state:
- state = INIT_WAIT, timer = 0, synchronizer flops = 0.
- wrt = 0, vld = 0, cmd = 0x0000, ptch = 0x0000, ptch_rt = 0x0000, byte holding registers = 0.
REQ-027 Reset asserted mid-transaction SHALL abandon the sequence.
REQ-028 After rst_n deasserts, the full init sequence SHALL repeat before any read.

Verification
REQ-029 Power-on, fast_sim=1, done returned 3 cycles after each wrt -> first wrt at cycle 1024 with cmd 0x0D02, then 0x1053, 0x1150, 0x1460 in order; no vld.
REQ-030 After init, INT=1; rd_data[7:0] returns 0x34, 0x12, 0xCD, 0xAB -> cmds 0xA200, 0xA300, 0xA400, 0xA500; one vld pulse; ptch=0x1234, ptch_rt=0xABCD.
REQ-031 INT held high continuously -> back-to-back sequences; each vld exactly one cycle; ptch stable between pulses.
REQ-032 INT pulsed high for 3 cycles during RD_PH -> no extra sequence once INT is low at return to IDLE; exactly one vld.
REQ-033 rst_n low during RD_RL -> all outputs 0 immediately; no vld; after release, init restarts with 0x0D02 at cycle 1024.
REQ-034 Spurious done pulse in IDLE -> no wrt, no state change, ptch/ptch_rt unchanged.
